// File: rtl/hit_serializer.sv
// hit_serializer: turns per-target hit levels into one queued event per
// target, then replays those events as spaced one-hot pulses on des, so a
// downstream counter that advances on "des non-zero" sees every hit once.
// Optional feature macro: HIT_SERIALIZER_DROP_CNT_EN adds drop_cnt, a
// saturating count of edges on which a rise hit an already-pending target.
module hit_serializer #(
  parameter int N         = 10,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] hit,
  input  logic         clear,
  output logic [N-1:0] des,
  output logic         busy,
  output logic [N-1:0] pending
`ifdef HIT_SERIALIZER_DROP_CNT_EN
  ,
  output logic [7:0]   drop_cnt
`endif
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW      = $clog2(MAX_LEN) + 1;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LEN - 1);
  localparam logic [N-1:0]  ONE_N      = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    des_q;
  logic [N-1:0]    hit_q;
  logic [N-1:0]    pending_q;
  logic [N-1:0]    pending_d;
  logic [N-1:0]    rise_s;
  logic [N-1:0]    lowest_s;
  logic [N-1:0]    take_s;

  // Edge detect, lowest-index pick, and the next pending mask.
  always_comb begin
    rise_s   = hit & ~hit_q;
    // Two's-complement trick isolates the lowest set bit of pending.
    lowest_s = pending_q & (~pending_q + ONE_N);
    if (state_q == S_IDLE) begin
      take_s = lowest_s;
    end else begin
      take_s = '0;
    end
    // A rise in the same cycle as clear or take survives and is replayed later.
    if (clear) begin
      pending_d = rise_s;
    end else begin
      pending_d = (pending_q & ~take_s) | rise_s;
    end
  end

  // Previous hit levels and the queue of pending events. hit_q resets to
  // all-ones so lines already high at reset release do not count as events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q     <= '1;
      pending_q <= '0;
    end else begin
      hit_q     <= hit;
      pending_q <= pending_d;
    end
  end

  // Pulse/gap sequencer: IDLE picks an event, PULSE holds des, GAP keeps it low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      des_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            des_q   <= take_s;
            cnt_q   <= PULSE_LOAD;
            state_q <= S_PULSE;
          end else begin
            des_q   <= '0;
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            des_q   <= '0;
            cnt_q   <= GAP_LOAD;
            state_q <= S_GAP;
          end else begin
            cnt_q   <= cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          des_q   <= '0;
        end
      endcase
    end
  end

`ifdef HIT_SERIALIZER_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Count edges that lost at least one event to an already-pending target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= 8'd0;
    end else if (clear) begin
      drop_cnt_q <= 8'd0;
    end else if ((|(rise_s & pending_q & ~take_s)) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_q <= drop_cnt_q;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign des     = des_q;
  assign pending = pending_q;
  assign busy    = (state_q != S_IDLE) | (|pending_q);

endmodule

// File: tb/tb_hit_serializer.sv
// Self-checking bench for hit_serializer: expected des codes are queued when
// hits are driven and popped when des starts a new pulse.
module tb_hit_serializer;

  localparam int N         = 10;
  localparam int PULSE_LEN = 4;
  localparam int GAP_LEN   = 4;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] hit;
  logic         clear;
  logic [N-1:0] des;
  logic         busy;
  logic [N-1:0] pending;
`ifdef HIT_SERIALIZER_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  hit_serializer #(.N(N), .PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hit      (hit),
    .clear    (clear),
    .des      (des),
    .busy     (busy),
    .pending  (pending)
`ifdef HIT_SERIALIZER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [N-1:0] sb_q[$];
  logic         sb_en    = 1'b1;
  int           pulse_cnt = 0;

  // Single comparison point: counts, and reports any mismatch.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: pops expected codes on each new pulse and checks pulse shape.
  logic [N-1:0] prev_des = '0;
  int           hi_len   = 0;
  int           lo_len   = 0;
  logic         seen_any = 1'b0;
  logic [N-1:0] exp_code;
  always @(negedge clk) begin
    if (des != '0) begin
      check_eq("des_onehot", 32'($onehot(des)), 32'd1);
      if (prev_des != '0) begin
        check_eq("des_stable", 32'(des), 32'(prev_des));
        hi_len++;
      end else begin
        pulse_cnt++;
        if (seen_any) check_eq("gap_len_min", 32'(lo_len >= GAP_LEN + 1), 32'd1);
        seen_any = 1'b1;
        if (sb_en) begin
          if (sb_q.size() == 0) begin
            check_eq("des_unexpected", 32'(des), 32'd0);
          end else begin
            exp_code = sb_q.pop_front();
            check_eq("des_code", 32'(des), 32'(exp_code));
          end
        end
        hi_len = 1;
      end
    end else begin
      if (prev_des != '0) begin
        check_eq("pulse_len", 32'(hi_len), 32'(PULSE_LEN));
        lo_len = 1;
      end else begin
        lo_len++;
      end
    end
    prev_des = des;
  end

  // Wait for the block to go idle within a cycle budget.
  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((busy || des != '0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_timeout", 32'(n < limit), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  int n;
  int base;

  initial begin
    reset_n = 1'b0;
    hit     = '0;
    clear   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_des", 32'(des), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
`ifdef HIT_SERIALIZER_DROP_CNT_EN
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single event: latency, pulse, busy fall.
    hit = 10'h001;
    sb_q.push_back(10'h001);
    @(posedge clk); #1;
    check_eq("lat_pending", 32'(pending), 32'h001);
    check_eq("lat_des_low", 32'(des), 32'd0);
    hit = '0;
    @(posedge clk); #1;
    check_eq("lat_des_high", 32'(des), 32'h001);
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("busy_fall", 32'(n), 32'd8);
    drain(100);

    // All ten targets rising together.
    base = pulse_cnt;
    hit = 10'h3FF;
    for (int i = 0; i < N; i++) sb_q.push_back(N'(1) << i);
    @(posedge clk); #1;
    hit = '0;
    drain(400);
    check_eq("all_pulse_cnt", 32'(pulse_cnt - base), 32'd10);
    check_eq("all_pending", 32'(pending), 32'd0);

    // Line held high across reset release is not an event.
    hit = 10'h004;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("held_des", 32'(des), 32'd0);
    check_eq("held_pending", 32'(pending), 32'd0);
    hit = '0;
    @(posedge clk); #1;
    hit = 10'h004;
    sb_q.push_back(10'h004);
    @(posedge clk); #1;
    hit = '0;
    drain(100);

    // Rise on bit 3 exactly on the edge pending[3] is taken.
    hit = 10'h009;
    sb_q.push_back(10'h001);
    sb_q.push_back(10'h008);
    sb_q.push_back(10'h008);
    @(posedge clk); #1;
    hit = '0;
    repeat (9) @(posedge clk);
    #1;
    hit = 10'h008;
    @(posedge clk); #1;
    check_eq("take_des", 32'(des), 32'h008);
    check_eq("take_repend", 32'(pending), 32'h008);
    hit = '0;
    drain(200);

    // Clear during the first pulse: pulse completes, rest flushed.
    base = pulse_cnt;
    hit = 10'h0F0;
    sb_q.push_back(10'h010);
    @(posedge clk); #1;
    hit = '0;
    n = 0;
    while (des == '0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("clear_wait", 32'(n < 20), 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_eq("clear_flush", 32'(pending), 32'd0);
    check_eq("clear_des_held", 32'(des), 32'h010);
    drain(100);
    check_eq("clear_pulse_cnt", 32'(pulse_cnt - base), 32'd1);

`ifdef HIT_SERIALIZER_DROP_CNT_EN
    // Second rise on a still-pending target is dropped and counted.
    hit = 10'h021;
    sb_q.push_back(10'h001);
    sb_q.push_back(10'h020);
    @(posedge clk); #1;
    hit = 10'h001;
    @(posedge clk); #1;
    hit = 10'h021;
    @(posedge clk); #1;
    check_eq("drop_one", 32'(drop_cnt), 32'd1);
    hit = '0;
    drain(100);

    // Many collisions saturate the counter; clear zeroes it.
    sb_en = 1'b0;
    for (int i = 0; i < 600; i++) begin
      hit = 10'h020;
      @(posedge clk); #1;
      hit = '0;
      @(posedge clk); #1;
    end
    drain(200);
    check_eq("drop_sat", 32'(drop_cnt), 32'd255);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_eq("drop_clear", 32'(drop_cnt), 32'd0);
    sb_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
